// File: rtl/if_id_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_fifo_if
//  Brief    : IF -> ID instruction queue handshake bundle (push, pop, flush).
//  Revision : 1.0 - initial release
// ============================================================================
interface if_id_fifo_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) ();
    logic                     flush;
    logic                     if_valid;
    logic [ADDR_W-1:0]        if_pc;
    logic [INST_W-1:0]        if_inst;
    logic                     if_ready;
    logic                     id_ready;
    logic                     id_valid;
    logic [ADDR_W-1:0]        id_pc;
    logic [INST_W-1:0]        id_inst;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, if_valid, if_pc, if_inst, id_ready,
        input  if_ready, id_valid, id_pc, id_inst, count
    );

    modport slave (
        input  flush, if_valid, if_pc, if_inst, id_ready,
        output if_ready, id_valid, id_pc, id_inst, count
    );
endinterface
`default_nettype wire

// File: rtl/if_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_fifo
//  Brief    : DEPTH-entry first-word-fall-through {pc, inst} queue, IF -> ID.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_fifo #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    if_id_fifo_if.slave bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_ent_w = ADDR_W + INST_W;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [c_ent_w-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_if_ready;
    logic               w_id_valid;
    logic               w_push;
    logic               w_pop;
    logic [c_ent_w-1:0] w_head;

    // if_ready comes from registered occupancy only, so a full queue refuses
    // a push even when ID pops in the same cycle.
    assign w_if_ready = (r_count != c_full);
    assign w_id_valid = (r_count != '0);
    assign w_push     = bus.if_valid & w_if_ready;
    assign w_pop      = bus.id_ready & w_id_valid;
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!reset && !bus.flush && w_push) begin
            r_mem[r_wr_ptr] <= {bus.if_pc, bus.if_inst};
        end
    end

    assign bus.if_ready = w_if_ready;
    assign bus.id_valid = w_id_valid;
    assign bus.id_pc    = w_id_valid ? w_head[c_ent_w-1:INST_W] : '0;
    assign bus.id_inst  = w_id_valid ? w_head[INST_W-1:0]       : '0;
    assign bus.count    = r_count;
endmodule
`default_nettype wire

// File: tb/tb_if_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_fifo
//  Brief    : Self-checking bench for if_id_fifo against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_fifo;
    localparam int c_aw    = 32;
    localparam int c_iw    = 32;
    localparam int c_depth = 4;

    logic clk;
    logic reset;

    if_id_fifo_if #(.ADDR_W(c_aw), .INST_W(c_iw), .DEPTH(c_depth)) bus ();

    if_id_fifo #(.ADDR_W(c_aw), .INST_W(c_iw), .DEPTH(c_depth)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of held entries plus a log of popped pcs.
    logic [63:0] m_q[$];
    logic [31:0] m_popped[$];
    bit          m_push;
    bit          m_pop;

    always @(posedge clk) begin
        if (reset || bus.flush) begin
            m_q.delete();
        end else begin
            m_push = bus.if_valid && (m_q.size() < c_depth);
            m_pop  = bus.id_ready && (m_q.size() != 0);
            if (m_pop) begin
                m_popped.push_back(m_q[0][63:32]);
                void'(m_q.pop_front());
            end
            if (m_push) m_q.push_back({bus.if_pc, bus.if_inst});
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_count",    64'(bus.count),    64'(m_q.size()));
            chk("cmp_id_valid", 64'(bus.id_valid), 64'(m_q.size() != 0));
            chk("cmp_if_ready", 64'(bus.if_ready), 64'(m_q.size() < c_depth));
            chk("cmp_id_pc",    64'(bus.id_pc),    (m_q.size() != 0) ? 64'(m_q[0][63:32]) : 64'd0);
            chk("cmp_id_inst",  64'(bus.id_inst),  (m_q.size() != 0) ? 64'(m_q[0][31:0])  : 64'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = 32'hA0 + ((pc - 32'h100) >> 2);
        bus.id_ready = rdy;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"},    64'(bus.count),    64'd0);
        chk({tag, "_id_valid"}, 64'(bus.id_valid), 64'd0);
        chk({tag, "_if_ready"}, 64'(bus.if_ready), 64'd1);
        chk({tag, "_id_pc"},    64'(bus.id_pc),    64'd0);
        chk({tag, "_id_inst"},  64'(bus.id_inst),  64'd0);
    endtask

    logic [31:0] next_pc;

    initial begin
        reset     = 1'b1;
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);

        // Reset and empty
        cyc();
        cmp_en = 1'b1;
        chk_reset_vals("rst1");
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_reset_vals("idle");
        end

        // Fill under stall, fifth entry refused
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0);
            cyc();
            chk("fill_count", 64'(bus.count), 64'((i < 4) ? i + 1 : 4));
            chk("fill_hold_pc", 64'(bus.id_pc), 64'h100);
        end
        chk("fill_if_ready", 64'(bus.if_ready), 64'd0);

        // Drain and wrap: IF re-presents an entry until it is accepted
        m_popped.delete();
        next_pc = 32'h110;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, next_pc, 1'b1);
            if (bus.if_ready) next_pc = next_pc + 32'd4;
            cyc();
            chk("drain_count", 64'(bus.count), 64'd3);
        end
        chk("drain_npop", 64'(m_popped.size()), 64'd12);
        for (int i = 0; i < m_popped.size(); i++) begin
            chk("drain_order", 64'(m_popped[i]), 64'(32'h100 + 32'(4 * i)));
        end

        // Flush during traffic drops both the push and the pop
        chk("pre_flush_count", 64'(bus.count), 64'd3);
        bus.flush = 1'b1;
        drive(1'b1, 32'h200, 1'b1);
        cyc();
        bus.flush = 1'b0;
        chk_reset_vals("flush");
        drive(1'b1, 32'h204, 1'b0);
        cyc();
        chk("post_flush_head", 64'(bus.id_pc), 64'h204);
        chk("post_flush_inst", 64'(bus.id_inst), 64'hE1);

        // Full plus simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h208 + 32'(4 * i), 1'b0);
            cyc();
        end
        chk("full_count", 64'(bus.count), 64'd4);
        drive(1'b1, 32'h300, 1'b1);
        cyc();
        chk("full_pp_count", 64'(bus.count), 64'd3);
        chk("full_pp_head", 64'(bus.id_pc), 64'h208);
        drive(1'b1, 32'h300, 1'b0);
        cyc();
        chk("full_retry_count", 64'(bus.count), 64'd4);

        // Reset mid-operation
        drive(1'b0, 32'h0, 1'b1);
        cyc();
        cyc();
        chk("pre_rst_count", 64'(bus.count), 64'd2);
        reset = 1'b1;
        drive(1'b1, 32'h400, 1'b1);
        cyc();
        chk_reset_vals("midrst1");
        cyc();
        chk_reset_vals("midrst2");
        reset = 1'b0;
        drive(1'b1, 32'h404, 1'b0);
        cyc();
        chk("post_rst_head", 64'(bus.id_pc), 64'h404);
        drive(1'b0, 32'h0, 1'b1);
        cyc();
        cyc();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
